// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed driver for a common-anode seven-segment display. Advances one
//   digit per rising edge of the divided 1 kHz clock, blanks every digit for
//   BLANK_CYCLES after each digit change to suppress ghosting, and shows digits
//   decoded from a snapshot of the inputs taken at the start of every frame.
//
// Ports
//   CLK       system clock (rising edge)
//   RST_N     asynchronous active-low reset
//   CLK_1K    divided scan clock, asynchronous; synchronised internally
//   VALUE     packed hex digits, VALUE[3:0] = digit 0 (rightmost)
//   DP        per-digit decimal-point request, active-high
//   LZ_BLANK  leading-zero blanking enable
//   SEG_N     segments g..a, active-low
//   DP_N      decimal point, active-low
//   AN_N      anode enables, active-low, one-hot-low or all high
//   FRAME     one-cycle pulse when digit 0 of a new frame is selected
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CLK_1K,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic                    LZ_BLANK,
  output logic [6:0]              SEG_N,
  output logic                    DP_N,
  output logic [NUM_DIGITS-1:0]   AN_N,
  output logic                    FRAME
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLANK_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, BLANK, SHOW} state_t;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;  4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;  4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;  4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;  4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;  4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;  4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;  4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;  default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Synchroniser + edge detector as one shift register:
  // [0]=sync1, [1]=sync2, [2]=previous sync2.
  logic [2:0] sync_pipe;
  logic       tick;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], CLK_1K};

  assign tick = sync_pipe[1] & ~sync_pipe[2];

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val, sh_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_d;
  logic                    sh_lz, sh_lz_d;
  logic                    snap;

  // Next state. A tick always wins: it advances the digit and (re)starts the
  // blank interval, whatever state we are in.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    snap    = 1'b0;
    if (tick) begin
      state_d = BLANK;
      cnt_d   = BLANK_LOAD;
      idx_d   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      snap    = (idx == LAST_IDX);
    end else if (state == BLANK) begin
      if (cnt == '0) state_d = SHOW;
      else           cnt_d   = cnt - 1'b1;
    end
  end

  assign sh_val_d = snap ? VALUE    : sh_val;
  assign sh_dp_d  = snap ? DP       : sh_dp;
  assign sh_lz_d  = snap ? LZ_BLANK : sh_lz;

  // Outputs are computed from the next-state values so the registered
  // outputs line up with the state they belong to.
  logic [6:0]            seg_n_d;
  logic                  dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_d;
  logic [3:0]            nib;
  logic                  upper_zero, lz_hit;

  always_comb begin
    nib        = sh_val_d[4*int'(idx_d) +: 4];
    upper_zero = 1'b1;
    lz_hit     = 1'b0;
    // Walk from the leftmost digit down; a digit is blanked when it and every
    // digit to its left are zero. Digit 0 is never reached, so never blanked.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (sh_val_d[4*i +: 4] == 4'h0);
      if (int'(idx_d) == i) lz_hit = upper_zero;
    end
    lz_hit = lz_hit & sh_lz_d;

    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (state_d == SHOW) begin
      an_n_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_n_d = lz_hit ? 7'h7F : ~hex_to_seg(nib);
      dp_n_d  = ~sh_dp_d[idx_d];
    end
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state  <= WAIT;
      cnt    <= '0;
      idx    <= LAST_IDX;
      sh_val <= '0;
      sh_dp  <= '0;
      sh_lz  <= 1'b0;
      SEG_N  <= 7'h7F;
      DP_N   <= 1'b1;
      AN_N   <= '1;
      FRAME  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      sh_val <= sh_val_d;
      sh_dp  <= sh_dp_d;
      sh_lz  <= sh_lz_d;
      SEG_N  <= seg_n_d;
      DP_N   <= dp_n_d;
      AN_N   <= an_n_d;
      FRAME  <= snap;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: scoreboard of expected digit displays and
// frame pulses produced by a reference model that works from the display
// rules directly (digit order, hex table, leading-zero rule, frame snapshot).
module tb_seg7_scan_driver;
  localparam int NUM_DIGITS   = 4;
  localparam int BLANK_CYCLES = 4;

  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic                    CLK_1K;
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic [NUM_DIGITS-1:0]   DP;
  logic                    LZ_BLANK;
  logic [6:0]              SEG_N;
  logic                    DP_N;
  logic [NUM_DIGITS-1:0]   AN_N;
  logic                    FRAME;

  seg7_scan_driver #(.NUM_DIGITS(NUM_DIGITS), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLK_1K(CLK_1K), .VALUE(VALUE), .DP(DP),
    .LZ_BLANK(LZ_BLANK), .SEG_N(SEG_N), .DP_N(DP_N), .AN_N(AN_N), .FRAME(FRAME)
  );

  logic clk_en = 1'b0;
  initial forever #5 if (clk_en) CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Active-high g..a patterns of the hex digits 0..F.
  logic [6:0] SEG_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
    int                    cyc;
  } exp_t;

  exp_t sq[$];   // expected digit displays, in order
  int   fq[$];   // expected FRAME cycles

  // Reference model state: currently selected digit and the frame snapshot.
  int                      m_idx;
  logic [4*NUM_DIGITS-1:0] m_val;
  logic [NUM_DIGITS-1:0]   m_dp;
  logic                    m_lz;
  logic [NUM_DIGITS-1:0]   one = 1;

  task automatic model_reset();
    m_idx = NUM_DIGITS - 1;
    m_val = '0; m_dp = '0; m_lz = 1'b0;
  endtask

  // One CLK_1K period: rise, stay high for hi cycles, low for lo cycles.
  // The DUT samples CLK_1K at the following posedge (E) and reacts at E+2,
  // i.e. 3 cycles after the driving negedge; the digit lights BLANK_CYCLES later.
  task automatic tick(input int hi, input int lo);
    exp_t e;
    int   dig;
    @(negedge CLK);
    CLK_1K = 1'b1;
    m_idx = (m_idx + 1) % NUM_DIGITS;
    if (m_idx == 0) begin
      m_val = VALUE; m_dp = DP; m_lz = LZ_BLANK;
      fq.push_back(cyc + 3);
    end
    dig   = int'((m_val >> (4*m_idx)) & 16'hF);
    e.an  = ~(one << m_idx);
    e.seg = (m_lz && m_idx != 0 && (m_val >> (4*m_idx)) == 0) ? 7'h7F : ~SEG_HI[dig];
    e.dp  = ~m_dp[m_idx];
    e.cyc = cyc + 3 + BLANK_CYCLES;
    sq.push_back(e);
    repeat (hi) @(negedge CLK);
    CLK_1K = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic tick_rand();
    tick($urandom_range(BLANK_CYCLES + 20, BLANK_CYCLES + 3),
         $urandom_range(BLANK_CYCLES + 20, BLANK_CYCLES + 3));
  endtask

  // A whole frame with fixed inputs; optional change after digit 1 shows.
  task automatic frame(input logic [15:0] v, input logic [3:0] d, input logic lz,
                       input logic chg, input logic [15:0] v2);
    VALUE = v; DP = d; LZ_BLANK = lz;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      tick_rand();
      if (chg && k == 1) VALUE = v2;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  exp_t cur;
  logic was_lit = 1'b0;
  int   frames_seen = 0;
  always @(negedge CLK) begin
    if (!RST_N) was_lit = 1'b0;
    else begin
      if (FRAME) begin
        frames_seen++;
        if (fq.size() == 0) chk("frame_unexpected", 1, 0);
        else chk("frame_cycle", fq.pop_front(), cyc);
      end
      if (fq.size() != 0 && cyc > fq[0]) chk("frame_missing", fq.pop_front(), 0);
      if (AN_N != '1) begin
        if (!was_lit) begin
          if (sq.size() == 0) chk("lit_unexpected", 32'(AN_N), 32'(~0 & 4'hF));
          else begin
            cur = sq.pop_front();
            chk("show_cycle", cyc, cur.cyc);
          end
        end
        chk("an",  32'(AN_N),  32'(cur.an));
        chk("seg", 32'(SEG_N), 32'(cur.seg));
        chk("dp",  32'(DP_N),  32'(cur.dp));
        was_lit = 1'b1;
      end else begin
        chk("off_seg_dp", {SEG_N, DP_N}, {7'h7F, 1'b1});
        was_lit = 1'b0;
      end
      if (sq.size() != 0 && cyc > sq[0].cyc) begin
        chk("show_missing", sq[0].cyc, cyc);
        void'(sq.pop_front());
      end
    end
  end

  initial begin
    RST_N = 1'b1; CLK_1K = 1'b0; VALUE = '0; DP = '0; LZ_BLANK = 1'b0;
    model_reset();

    // Reset with the clock stopped: outputs must go off asynchronously.
    #1 RST_N = 1'b0;
    #1;
    chk("rst_seg",   32'(SEG_N), 32'h7F);
    chk("rst_dp",    32'(DP_N),  32'h1);
    chk("rst_an",    32'(AN_N),  32'hF);
    chk("rst_frame", 32'(FRAME), 32'h0);
    clk_en = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    // Idle with CLK_1K low: nothing should light and no frame should start.
    repeat (1000) @(negedge CLK);
    chk("idle_frames", frames_seen, 0);
    chk("idle_an", 32'(AN_N), 32'hF);

    // Basic scan, then wrap to digit 0 of the next frame.
    frame(16'h1234, 4'b0000, 1'b0, 1'b0, 16'h0);
    // Snapshot coherence: change to ABCD while digit 1 is shown.
    frame(16'h1234, 4'b0000, 1'b0, 1'b1, 16'hABCD);
    frame(16'hABCD, 4'b0000, 1'b0, 1'b0, 16'h0);
    // Leading-zero blanking.
    frame(16'h0050, 4'b0000, 1'b1, 1'b0, 16'h0);
    frame(16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0);
    frame(16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0);
    // Decimal point on digit 2 only.
    frame(16'h5678, 4'b0100, 1'b0, 1'b0, 16'h0);

    // Randomised frames, with leading zeros encouraged and mid-frame changes.
    for (int f = 0; f < 20; f++) begin
      VALUE    = 16'($urandom) >> (4 * $urandom_range(3, 0));
      DP       = 4'($urandom);
      LZ_BLANK = 1'($urandom);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        tick_rand();
        if ($urandom_range(2, 0) == 0) begin
          VALUE = 16'($urandom); DP = 4'($urandom); LZ_BLANK = 1'($urandom);
        end
      end
    end

    // Async reset while digit 2 is lit (CLK_1K low, so no tick on release).
    VALUE = 16'h9876; DP = 4'b0000; LZ_BLANK = 1'b0;
    tick_rand(); tick_rand(); tick_rand();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_an",  32'(AN_N),  32'hF);
    chk("midrst_seg", {SEG_N, DP_N}, {7'h7F, 1'b1});
    chk("midrst_pending", sq.size() + fq.size(), 0);
    sq.delete(); fq.delete();
    model_reset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    // Fresh frame after reset must restart at digit 0 with a new snapshot.
    frame(16'h0C1E, 4'b1001, 1'b1, 1'b0, 16'h0);

    for (int i = 0; i < 200 && (sq.size() != 0 || fq.size() != 0); i++) @(negedge CLK);
    chk("drain", sq.size() + fq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
